// File: rtl/ma_stage_pkg.sv
// rv32_ma_pkg: opcodes, funct3 codes and FSM states shared by the memory-access stage.
package rv32_ma_pkg;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} ma_state_e;
endpackage

// File: rtl/ma_load_align.sv
// ma_load_align: selects the addressed byte/halfword of a load word and sign/zero-extends it.
module ma_load_align
  import rv32_ma_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];
  assign value = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_BU ? {24'b0, b} :
                 funct3 == F3_HU ? {16'b0, h} : rdata;
endmodule

// File: rtl/ma_stage.sv
// ma_stage: RV32 memory-access stage driving a req/gnt/rvalid data bus with timeout.
// Define MA_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module ma_stage
  import rv32_ma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ma_inst,
  input  logic [31:0] ma_pc,
  input  logic [31:0] ma_alu_out,
  input  logic [31:0] ma_rs2_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        ma_stall,
  output logic [31:0] ma_result,
  output logic        ma_bus_err,
  output logic        ma_misalign
);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  ma_state_e st, nxt;
  logic [TMO_W-1:0] cnt;
  logic [31:0] rd_q, ld_val;
  logic err_q, mis_q, is_load, is_store, is_mem, mis_cond, busy, fin_ok, tmo_hit, cap;
  logic [2:0] f3;
  logic [1:0] sz;
  logic unused;
  assign unused = ^{ma_pc, ma_inst[31:15], ma_inst[11:7]};
  assign f3 = ma_inst[14:12];
  assign sz = f3[1:0];
  assign is_load  = ma_inst[6:0] == OPC_LOAD && f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign is_store = ma_inst[6:0] == OPC_STORE && f3 inside {F3_B, F3_H, F3_W};
  assign is_mem = is_load | is_store;
`ifdef MA_MISALIGN_TRAP_EN
  assign mis_cond = (sz == 2'b01 && ma_alu_out[0]) || (sz == 2'b10 && |ma_alu_out[1:0]);
  assign ma_misalign = st == DONE && mis_q;
`else
  assign mis_cond = 1'b0;
  assign ma_misalign = 1'b0;
`endif
  assign dmem_req   = st == REQ;
  assign dmem_we    = is_store;
  assign dmem_addr  = {ma_alu_out[31:2], 2'b00};
  assign dmem_be    = sz == 2'b00 ? 4'b0001 << ma_alu_out[1:0] :
                      sz == 2'b01 ? 4'b0011 << {ma_alu_out[1], 1'b0} : 4'b1111;
  assign dmem_wdata = sz == 2'b00 ? {4{ma_rs2_data[7:0]}} :
                      sz == 2'b01 ? {2{ma_rs2_data[15:0]}} : ma_rs2_data;
  ma_load_align u_align (
    .rdata (dmem_rdata),
    .off   (ma_alu_out[1:0]),
    .funct3(f3),
    .value (ld_val)
  );
  assign busy    = st == REQ || st == RESP;
  assign fin_ok  = (st == REQ && dmem_gnt) || (st == RESP && dmem_rvalid);
  // Completion wins over a timeout landing in the same cycle.
  assign tmo_hit = busy && !fin_ok && TIMEOUT_CYCLES != 0 && cnt == TMO_LAST;
  assign cap     = (st == REQ && dmem_gnt && is_load && dmem_rvalid) || (st == RESP && dmem_rvalid);
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = !is_mem ? IDLE : mis_cond ? DONE : REQ;
      REQ:  nxt = dmem_gnt ? ((is_store || dmem_rvalid) ? DONE : RESP) : tmo_hit ? DONE : REQ;
      RESP: nxt = (dmem_rvalid || tmo_hit) ? DONE : RESP;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign ma_stall   = (st == IDLE && is_mem) || busy;
  assign ma_bus_err = st == DONE && err_q;
  assign ma_result  = st != DONE ? ma_alu_out : mis_q ? 32'b0 : is_load ? rd_q : ma_alu_out;
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= IDLE;
      cnt   <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      st    <= nxt;
      cnt   <= busy ? cnt + TMO_W'(1) : '0;
      rd_q  <= cap ? ld_val : tmo_hit ? 32'b0 : rd_q;
      err_q <= tmo_hit;
      mis_q <= st == IDLE && is_mem && mis_cond;
    end
  end
endmodule
